// File: rtl/btn_debounce_pkg.sv
// Shared constants for the push-button conditioning path.
// The simulation debounce depth lives here so the button peripheral and the
// top level agree on the same channel count and timing.
package btn_debounce_pkg;

    localparam int BTN_WIDTH           = 5;
    localparam int BTN_DEBOUNCE_CYCLES = 1000000;  // 10 ms at 100 MHz
    localparam int BTN_DEBOUNCE_SIM    = 4;        // short depth for simulation builds
    localparam int BTN_CNT_W           = 20;

endpackage

// File: rtl/btn_debounce_bit.sv
// One button channel: 2-flop synchroniser, stability counter, registered
// stable level and a one-cycle pulse on each accepted 0->1 transition.
module btn_debounce_bit
    import btn_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES,
    parameter int CNT_W           = BTN_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_stable,
    output logic btn_rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s0_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_q;
    logic             stable_d;
    logic             rise_q;
    logic             rise_d;

    // Counter runs only while the synchronised input disagrees with the
    // accepted level; any bounce back clears it, so it can never wrap.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (s0_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = s0_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        rise_d = stable_d & ~stable_q;
    end

    // Synchroniser, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s0_q     <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            s1_q     <= btn_raw;
            s0_q     <= s1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
        end
    end

    assign btn_stable = stable_q;
    assign btn_rise   = rise_q;

endmodule

// File: rtl/btn_debounce.sv
// Debounces WIDTH raw button pins for the button peripheral.
// Build option BTN_ONEHOT_EN: outputs are reduced to at most one hot bit
// (lowest debounced channel wins) through one extra register stage.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int WIDTH           = BTN_WIDTH,
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES,
    parameter int CNT_W           = BTN_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_stable,
    output logic [WIDTH-1:0] btn_rise
);

    logic [WIDTH-1:0] stable_vec;
    logic [WIDTH-1:0] rise_vec;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        btn_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk        (clk),
            .rst        (rst),
            .btn_raw    (btn_raw[i]),
            .btn_stable (stable_vec[i]),
            .btn_rise   (rise_vec[i])
        );
    end

`ifdef BTN_ONEHOT_EN
    logic [WIDTH-1:0] onehot_q;
    logic [WIDTH-1:0] onehot_d;
    logic [WIDTH-1:0] orise_q;
    logic [WIDTH-1:0] orise_d;

    // Isolate the lowest set bit; a pulse fires whenever a bit becomes the
    // winner, including a higher channel taking over after a release.
    always_comb begin
        onehot_d = stable_vec & (~stable_vec + WIDTH'(1));
        orise_d  = onehot_d & ~onehot_q;
    end

    // Registered one-hot filter stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            onehot_q <= '0;
            orise_q  <= '0;
        end else begin
            onehot_q <= onehot_d;
            orise_q  <= orise_d;
        end
    end

    assign btn_stable = onehot_q;
    assign btn_rise   = orise_q;

    logic unused_rise;
    assign unused_rise = ^rise_vec;
`else
    assign btn_stable = stable_vec;
    assign btn_rise   = rise_vec;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
module tb_btn_debounce;

    localparam int D = 4;
`ifdef BTN_ONEHOT_EN
    localparam int LAT = D + 3;
`else
    localparam int LAT = D + 2;
`endif

    logic       clk;
    logic       rst;
    logic [4:0] btn_raw;
    logic [4:0] btn_stable;
    logic [4:0] btn_rise;

    int vecs = 0;
    int errs = 0;

    btn_debounce #(
        .WIDTH           (5),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_stable (btn_stable),
        .btn_rise   (btn_rise)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [4:0] raw);
        btn_raw = raw;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        btn_raw = 5'b00000;
        rst = 1'b1;
        step();
        vecs++;
        if (btn_stable !== 5'b00000 || btn_rise !== 5'b00000) begin
            $display("FAIL reset_asserted: stable=%b rise=%b, want 00000/00000", btn_stable, btn_rise);
            errs++;
        end
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            vecs++;
            if (btn_stable !== 5'b00000 || btn_rise !== 5'b00000) begin
                $display("FAIL idle_zero cyc %0d: stable=%b rise=%b, want 00000/00000", k, btn_stable, btn_rise);
                errs++;
            end
        end
    endtask

    task automatic test_press_release();
        logic [4:0] es, er;
        do_reset(5'b00000);
        btn_raw = 5'b00001;
        for (int k = 1; k <= LAT; k++) begin
            step();
            es = (k == LAT) ? 5'b00001 : 5'b00000;
            er = es;
            vecs++;
            if (btn_stable !== es || btn_rise !== er) begin
                $display("FAIL press edge %0d: stable=%b rise=%b, want %b/%b", k, btn_stable, btn_rise, es, er);
                errs++;
            end
        end
        step();
        vecs++;
        if (btn_stable !== 5'b00001 || btn_rise !== 5'b00000) begin
            $display("FAIL press_hold: stable=%b rise=%b, want 00001/00000", btn_stable, btn_rise);
            errs++;
        end
        btn_raw = 5'b00000;
        for (int k = 1; k <= LAT; k++) begin
            step();
            es = (k < LAT) ? 5'b00001 : 5'b00000;
            vecs++;
            if (btn_stable !== es || btn_rise !== 5'b00000) begin
                $display("FAIL release edge %0d: stable=%b rise=%b, want %b/00000", k, btn_stable, btn_rise, es);
                errs++;
            end
        end
    endtask

    task automatic test_glitch();
        do_reset(5'b00000);
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 6; k++) begin
                btn_raw = (k < 3) ? 5'b00100 : 5'b00000;
                step();
                vecs++;
                if (btn_stable !== 5'b00000 || btn_rise !== 5'b00000) begin
                    $display("FAIL glitch rep %0d cyc %0d: stable=%b rise=%b, want 00000/00000", r, k, btn_stable, btn_rise);
                    errs++;
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] es;
        do_reset(5'b00000);
        btn_raw = 5'b00100;
        repeat (LAT) step();
        vecs++;
        if (btn_stable !== 5'b00100) begin
            $display("FAIL midrst_accept: stable=%b, want 00100", btn_stable);
            errs++;
        end
        btn_raw = 5'b00000;
        rst = 1'b1;
        step();
        rst = 1'b0;
        vecs++;
        if (btn_stable !== 5'b00000 || btn_rise !== 5'b00000) begin
            $display("FAIL midrst_clear: stable=%b rise=%b, want 00000/00000", btn_stable, btn_rise);
            errs++;
        end
        btn_raw = 5'b00100;
        for (int k = 1; k <= LAT; k++) begin
            step();
            es = (k == LAT) ? 5'b00100 : 5'b00000;
            vecs++;
            if (btn_stable !== es || btn_rise !== es) begin
                $display("FAIL midrst_reaccept edge %0d: stable=%b rise=%b, want %b/%b", k, btn_stable, btn_rise, es, es);
                errs++;
            end
        end
        // Partial count then reset must restart the full debounce window.
        do_reset(5'b00000);
        btn_raw = 5'b01000;
        repeat (LAT - 1) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            step();
            es = (k == LAT) ? 5'b01000 : 5'b00000;
            vecs++;
            if (btn_stable !== es) begin
                $display("FAIL partial_discard edge %0d: stable=%b, want %b", k, btn_stable, es);
                errs++;
            end
        end
    endtask

    task automatic test_multi();
        logic [4:0] es, er, acc, after_s, after_r;
`ifdef BTN_ONEHOT_EN
        acc = 5'b00010;
`else
        acc = 5'b10010;
`endif
        do_reset(5'b00000);
        btn_raw = 5'b10010;
        for (int k = 1; k <= LAT; k++) begin
            step();
            es = (k == LAT) ? acc : 5'b00000;
            vecs++;
            if (btn_stable !== es || btn_rise !== es) begin
                $display("FAIL multi_press edge %0d: stable=%b rise=%b, want %b/%b", k, btn_stable, btn_rise, es, es);
                errs++;
            end
        end
        btn_raw = 5'b10000;
        for (int k = 1; k <= LAT; k++) begin
            step();
            after_s = 5'b10000;
`ifdef BTN_ONEHOT_EN
            after_r = 5'b10000;
`else
            after_r = 5'b00000;
`endif
            es = (k < LAT) ? acc : after_s;
            er = (k < LAT) ? 5'b00000 : after_r;
            vecs++;
            if (btn_stable !== es || btn_rise !== er) begin
                $display("FAIL multi_release edge %0d: stable=%b rise=%b, want %b/%b", k, btn_stable, btn_rise, es, er);
                errs++;
            end
        end
    endtask

    task automatic test_held_through_reset();
        logic [4:0] es;
        do_reset(5'b00001);
        for (int k = 1; k <= LAT + 1; k++) begin
            step();
            es = (k >= LAT) ? 5'b00001 : 5'b00000;
            vecs++;
            if (btn_stable !== es || btn_rise !== ((k == LAT) ? 5'b00001 : 5'b00000)) begin
                $display("FAIL held_reset edge %0d: stable=%b rise=%b, want stable %b", k, btn_stable, btn_rise, es);
                errs++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        btn_raw = 5'b00000;
        test_reset();
        test_press_release();
        test_glitch();
        test_reset_mid();
        test_multi();
        test_held_through_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
